cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Stage 1 forms per-bit generate/propagate and per-group G/P. Stage 2 resolves group carries, sum, carry-out and overflow.
- Valid/ready handshakes on both sides, so it can sit between the operand latch and writeback under stalls.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of GROUP.
- GROUP, 8, bits per lookahead group; WIDTH/GROUP groups total.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block accepts the input this cycle.
- opA  in  WIDTH  operand A.
- opB  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 reserved (treated as ADD).
- cin  in  1  carry-in, used only by ADDC.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.

Behaviour:
- Reset state: all registers clear.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset release.
- Operand conditioning before stage 1:
  - SUB uses Beff=~opB, c0=1.
  - ADD uses Beff=opB, c0=0.
  - ADDC uses Beff=opB, c0=cin.
- Stage 1 register, loaded on in_valid&&in_ready: s1_valid, A, Beff, c0, and per-bit g=A&Beff, p=A|Beff.
  - Also loaded: per-group G/P, where G_k = g_top | p_top&g_top-1 | ... and P_k = AND of the group's p.
- Stage 2 register:
  - Group carries: C_{k+1} = G_k | P_k&C_k, with C_0=c0.
  - In-group ripple via lookahead equations from the stage-1 g/p.
  - sum_i = A_i ^ Beff_i ^ c_i.
  - cout = C_{WIDTH/GROUP}.
  - ovf = c_{WIDTH-1} ^ c_WIDTH.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput: 1 per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready and register state; no path from in_valid.
- Stall: out_valid && !out_ready holds sum/cout/ovf stable. Stage 1 holds if full. in_ready drops only when both stages are full.
- Bubbles: stage 2 loads s1_valid=0 when s2_adv and stage 1 is empty. out_valid falls after a consumed result if no new data follows.
- Simultaneous events: accept, advance and output consume in the same cycle are all legal, giving full throughput.
- Wrap-around: results are modulo 2^WIDTH; cout and ovf report the excess.
- Reset mid-operation: in-flight results are discarded, no output is produced for them, and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: when ovf=1, sum is replaced in stage 2 by the signed saturation limit.
  - Positive overflow gives 0 followed by WIDTH-1 ones.
  - Negative overflow gives 1 followed by zeros.
  - cout and ovf are unchanged.
  - Adds port sat_en (in, 1), sampled with the operands; saturation applies only when sat_en=1.
- Not defined: no sat_en port; sum always wraps.

Decomposition:
- Package cla_pkg holds:
  - op encodings ADD/SUB/ADDC as a 2-bit typedef;
  - default WIDTH/GROUP constants;
  - a compile-time check function that WIDTH%GROUP==0.
- One sub-module, cla_group_gp, parametrised on GROUP.
  - Input: GROUP bits of A and Beff.
  - Output: bitwise g/p plus group G/P.
  - Instantiated WIDTH/GROUP times in stage 1.

Test Plan:
- ADD 0x0000_0001 + 0xFFFF_FFFF, out_ready=1 → after 2 cycles sum=0, cout=1, ovf=0.
- SUB 0x8000_0000 − 0x0000_0001 → sum=0x7FFF_FFFF, cout=1, ovf=1; with CLA_SAT_EN and sat_en=1, sum=0x8000_0000.
- ADDC 0x7FFF_FFFF + 0 with cin=1 → sum=0x8000_0000, ovf=1, cout=0.
- Back-to-back stream of 10 ops with out_ready=1 → 10 consecutive out_valid cycles, in order, in_ready constantly 1.
- Hold out_ready=0 for 4 cycles during a stream → sum held stable, in_ready=0 from the 3rd cycle, no loss or duplication after release.
- Assert reset_n=0 with both stages full → out_valid=0 and sum=0 immediately; first op after release emerges exactly 2 cycles after accept.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
package cla_pkg;

   // Operation select; the reserved code behaves as ADD.
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDC = 2'b10,
      OP_RSVD = 2'b11
   } opT;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_GROUP = 8;

   // Elaboration-time sanity check: the datapath must split into whole groups.
   function automatic bit geometryOk(input int unsigned width, input int unsigned group);
      return (group != 0) && (width != 0) && ((width % group) == 0);
   endfunction

endpackage : cla_pkg

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// Optional macro CLA_SAT_EN adds the sat_en operand-side flag.
interface cla_pipe_adder_if
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   opT               op;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef CLA_SAT_EN
   logic             sat_en;

   modport master (
      output in_valid, opA, opB, op, cin, sat_en, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, opA, opB, op, cin, sat_en, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, opA, opB, op, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, opA, opB, op, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`endif

endinterface : cla_pipe_adder_if

// File: rtl/cla_group_gp.sv
// Per-bit generate/propagate and group-level G/P for one lookahead group.
module cla_group_gp #(
   parameter int unsigned GROUP = 8
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   output logic [GROUP-1:0] g,
   output logic [GROUP-1:0] p,
   output logic             grpG,
   output logic             grpP
);

   assign g    = a & b;
   assign p    = a | b;
   assign grpP = &p;

   // Group generate: fold from LSB so higher bits dominate (g_top | p_top & ...).
   always_comb begin
      grpG = g[0];
      for (int j = 1; j < int'(GROUP); j++) begin
         grpG = g[j] | (p[j] & grpG);
      end
   end

endmodule : cla_group_gp

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers operands plus bit/group G/P; stage 2 resolves carries and the result.
// Optional macro CLA_SAT_EN: saturate sum on signed overflow when sat_en is set.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned GROUP = DEF_GROUP
) (
   input  logic           clock,
   input  logic           reset_n,
   cla_pipe_adder_if.slave bus
);

   localparam int unsigned NGRP = WIDTH / GROUP;

   if (!geometryOk(WIDTH, GROUP)) begin : gBadGeometry
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
   end

   logic             s2Adv;
   logic             s1Adv;
   logic [WIDTH-1:0] bEff;
   logic             c0;
   logic [WIDTH-1:0] gBit;
   logic [WIDTH-1:0] pBit;
   logic [NGRP-1:0]  grpG;
   logic [NGRP-1:0]  grpP;

   logic             s1Valid;
   logic [WIDTH-1:0] s1A;
   logic [WIDTH-1:0] s1B;
   logic             s1C0;
   logic [WIDTH-1:0] s1G;
   logic [WIDTH-1:0] s1P;
   logic [NGRP-1:0]  s1GrpG;
   logic [NGRP-1:0]  s1GrpP;
`ifdef CLA_SAT_EN
   logic             s1Sat;
`endif

   logic [WIDTH-1:0] sumNext;
   logic             coutNext;
   logic             ovfNext;

   logic             outValid;
   logic [WIDTH-1:0] sumQ;
   logic             coutQ;
   logic             ovfQ;

   // Pipeline advance: a stage moves when its downstream slot is free or draining.
   assign s2Adv = !outValid || bus.out_ready;
   assign s1Adv = !s1Valid || s2Adv;

   // Operand conditioning: SUB inverts B and injects a carry; ADDC takes cin.
   always_comb begin
      bEff = bus.opB;
      c0   = 1'b0;
      case (bus.op)
         OP_SUB:  begin
            bEff = ~bus.opB;
            c0   = 1'b1;
         end
         OP_ADDC: c0 = bus.cin;
         default: ;
      endcase
   end

   for (genvar k = 0; k < int'(NGRP); k++) begin : gGrp
      cla_group_gp #(.GROUP(GROUP)) uGroupGp (
         .a    (bus.opA[k*GROUP +: GROUP]),
         .b    (bEff[k*GROUP +: GROUP]),
         .g    (gBit[k*GROUP +: GROUP]),
         .p    (pBit[k*GROUP +: GROUP]),
         .grpG (grpG[k]),
         .grpP (grpP[k])
      );
   end

   // Stage 1 register: conditioned operands and lookahead terms.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1Valid <= 1'b0;
         s1A     <= '0;
         s1B     <= '0;
         s1C0    <= 1'b0;
         s1G     <= '0;
         s1P     <= '0;
         s1GrpG  <= '0;
         s1GrpP  <= '0;
`ifdef CLA_SAT_EN
         s1Sat   <= 1'b0;
`endif
      end else if (s1Adv) begin
         s1Valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1A    <= bus.opA;
            s1B    <= bEff;
            s1C0   <= c0;
            s1G    <= gBit;
            s1P    <= pBit;
            s1GrpG <= grpG;
            s1GrpP <= grpP;
`ifdef CLA_SAT_EN
            s1Sat  <= bus.sat_en;
`endif
         end
      end
   end

   // Stage 2 logic: group carry chain, in-group lookahead, sum, cout and overflow.
   always_comb begin : s2Comb
      logic [NGRP:0]  grpC;
      logic [WIDTH:0] c;
      grpC    = '0;
      c       = '0;
      grpC[0] = s1C0;
      for (int k = 0; k < int'(NGRP); k++) begin
         grpC[k+1] = s1GrpG[k] | (s1GrpP[k] & grpC[k]);
      end
      c[0] = grpC[0];
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (((i + 1) % int'(GROUP)) == 0) begin
            c[i+1] = grpC[(i + 1) / int'(GROUP)];
         end else begin
            c[i+1] = s1G[i] | (s1P[i] & c[i]);
         end
      end
      sumNext  = s1A ^ s1B ^ c[WIDTH-1:0];
      coutNext = c[WIDTH];
      ovfNext  = c[WIDTH-1] ^ c[WIDTH];
`ifdef CLA_SAT_EN
      // Carry-out clear on overflow means both operands were non-negative.
      if (s1Sat && ovfNext) begin
         sumNext = {c[WIDTH], {(WIDTH-1){~c[WIDTH]}}};
      end
`endif
   end

   // Stage 2 register: result held while the consumer stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outValid <= 1'b0;
         sumQ     <= '0;
         coutQ    <= 1'b0;
         ovfQ     <= 1'b0;
      end else if (s2Adv) begin
         outValid <= s1Valid;
         if (s1Valid) begin
            sumQ  <= sumNext;
            coutQ <= coutNext;
            ovfQ  <= ovfNext;
         end
      end
   end

   assign bus.in_ready  = s1Adv;
   assign bus.out_valid = outValid;
   assign bus.sum       = sumQ;
   assign bus.cout      = coutQ;
   assign bus.ovf       = ovfQ;

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (honours CLA_SAT_EN when defined).
module tb_cla_pipe_adder;
   import cla_pkg::*;

   localparam int unsigned W = 32;
   localparam int NVEC = 12;

   typedef struct {
      opT          op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sat;
      logic [31:0] s;
      logic [31:0] satS;
      logic        co;
      logic        ov;
   } vecT;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   cla_pipe_adder_if #(.WIDTH(W)) bus ();

   cla_pipe_adder #(.WIDTH(W), .GROUP(8)) dut (
      .clock   (clk),
      .reset_n (rstN),
      .bus     (bus)
   );

   int   checks = 0;
   int   errors = 0;
   vecT  vecs [NVEC];
   int   q [$];
   int   curIdx = 0;
   bit   sbEn = 1'b0;
   int   accCount = 0;
   int   outCount = 0;
   bit   heldValid = 1'b0;
   logic [31:0] heldSum;
   logic heldCo;
   logic heldOv;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic vecT mk(opT op, logic [31:0] a, logic [31:0] b, logic cin, logic sat,
                              logic [31:0] s, logic [31:0] satS, logic co, logic ov);
      vecT v;
      v.op = op; v.a = a; v.b = b; v.cin = cin; v.sat = sat;
      v.s = s; v.satS = satS; v.co = co; v.ov = ov;
      return v;
   endfunction

   function automatic logic [31:0] expSum(int idx);
`ifdef CLA_SAT_EN
      if (vecs[idx].sat) return vecs[idx].satS;
`endif
      return vecs[idx].s;
   endfunction

   task automatic drive(input int idx);
      bus.in_valid = 1'b1;
      bus.op       = vecs[idx].op;
      bus.opA      = vecs[idx].a;
      bus.opB      = vecs[idx].b;
      bus.cin      = vecs[idx].cin;
`ifdef CLA_SAT_EN
      bus.sat_en   = vecs[idx].sat;
`endif
      curIdx       = idx;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.op       = OP_ADD;
      bus.opA      = '0;
      bus.opB      = '0;
      bus.cin      = 1'b0;
`ifdef CLA_SAT_EN
      bus.sat_en   = 1'b0;
`endif
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: sampled mid-cycle, judges the handshakes of the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sbEn) begin
            if (heldValid && bus.out_valid) begin
               check("hold_sum", 64'(bus.sum), 64'(heldSum));
               check("hold_cout", 64'(bus.cout), 64'(heldCo));
               check("hold_ovf", 64'(bus.ovf), 64'(heldOv));
            end
            heldValid = bus.out_valid && !bus.out_ready;
            heldSum   = bus.sum;
            heldCo    = bus.cout;
            heldOv    = bus.ovf;
            if (bus.out_valid && bus.out_ready) begin
               check("out_expected", 64'(q.size() > 0), 64'(1));
               if (q.size() > 0) begin
                  int idx;
                  idx = q.pop_front();
                  check($sformatf("sum_v%0d", idx), 64'(bus.sum), 64'(expSum(idx)));
                  check($sformatf("cout_v%0d", idx), 64'(bus.cout), 64'(vecs[idx].co));
                  check($sformatf("ovf_v%0d", idx), 64'(bus.ovf), 64'(vecs[idx].ov));
               end
               outCount++;
            end
            if (bus.in_valid && bus.in_ready) begin
               q.push_back(curIdx);
               accCount++;
            end
         end
      end
   end

   initial begin
      int  nextIdx;
      bit  acc;
      bit  expRdy [4];

      vecs[0]  = mk(OP_ADD,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
      vecs[1]  = mk(OP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      vecs[2]  = mk(OP_ADDC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      vecs[3]  = mk(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
      vecs[4]  = mk(OP_SUB,  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0);
      vecs[5]  = mk(OP_SUB,  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0);
      vecs[6]  = mk(OP_ADDC, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0);
      vecs[7]  = mk(OP_ADD,  32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
      vecs[8]  = mk(OP_RSVD, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_6789, 32'h2345_6789, 1'b0, 1'b0);
      vecs[9]  = mk(OP_ADD,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
      vecs[10] = mk(OP_ADDC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      vecs[11] = mk(OP_SUB,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

      // Reset values.
      rstN = 1'b0;
      idle();
      bus.out_ready = 1'b0;
      repeat (3) nextCycle();
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_sum", 64'(bus.sum), 64'(0));
      check("rst_cout", 64'(bus.cout), 64'(0));
      check("rst_ovf", 64'(bus.ovf), 64'(0));
      @(negedge clk);
      rstN = 1'b1;
      nextCycle();
      check("rel_in_ready", 64'(bus.in_ready), 64'(1));

      // Single op: two-cycle latency, bubble afterwards.
      bus.out_ready = 1'b1;
      sbEn = 1'b1;
      drive(0);
      nextCycle();
      idle();
      check("lat_cycle1", 64'(bus.out_valid), 64'(0));
      nextCycle();
      check("lat_cycle2", 64'(bus.out_valid), 64'(1));
      check("lat_sum", 64'(bus.sum), 64'(32'h0000_0000));
      nextCycle();
      check("bubble_out_valid", 64'(bus.out_valid), 64'(0));

      // Back-to-back stream at full throughput.
      for (int c = 0; c < 16; c++) begin
         if (c < NVEC) drive(c);
         else idle();
         @(negedge clk);
         if (c < NVEC) check($sformatf("stream_rdy_c%0d", c), 64'(bus.in_ready), 64'(1));
         check($sformatf("stream_ov_c%0d", c), 64'(bus.out_valid), 64'((c >= 2) && (c <= 13)));
         nextCycle();
      end

      // Consumer stall for the first four cycles of a stream.
      expRdy = '{1'b1, 1'b1, 1'b0, 1'b0};
      nextIdx = 0;
      for (int c = 0; c < 40; c++) begin
         bus.out_ready = (c >= 4);
         if (nextIdx < NVEC) drive(nextIdx);
         else idle();
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (c < 4) check($sformatf("stall_rdy_c%0d", c), 64'(bus.in_ready), 64'(expRdy[c]));
         if (c == 4) check("release_rdy", 64'(bus.in_ready), 64'(1));
         nextCycle();
         if (acc) nextIdx++;
      end
      idle();
      check("stall_all_sent", 64'(nextIdx), 64'(NVEC));
      check("stall_drained", 64'(q.size()), 64'(0));
      check("acc_vs_out", 64'(outCount), 64'(accCount));

      // Fill both stages, then reset asynchronously mid-cycle.
      bus.out_ready = 1'b0;
      drive(3);
      nextCycle();
      drive(4);
      nextCycle();
      idle();
      @(negedge clk);
      check("full_out_valid", 64'(bus.out_valid), 64'(1));
      check("full_in_ready", 64'(bus.in_ready), 64'(0));
      #2;
      sbEn = 1'b0;
      rstN = 1'b0;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'(0));
      check("arst_sum", 64'(bus.sum), 64'(0));
      check("arst_in_ready", 64'(bus.in_ready), 64'(1));
      q.delete();
      heldValid = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      bus.out_ready = 1'b1;
      nextCycle();
      sbEn = 1'b1;
      drive(10);
      nextCycle();
      idle();
      check("post_rst_lat1", 64'(bus.out_valid), 64'(0));
      nextCycle();
      check("post_rst_lat2", 64'(bus.out_valid), 64'(1));
      check("post_rst_sum", 64'(bus.sum), 64'(32'hFFFF_FFFF));
      nextCycle();
      check("post_rst_drained", 64'(q.size()), 64'(0));
      check("post_rst_idle", 64'(bus.out_valid), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cla_pipe_adder
